uart_rx: RTL
============

# uart_rx

Serial receiver paired with `uart_tx`; consumes the `txd` line (directly in loopback, or from an external pin) and recovers 8N1 bytes. Uses a 16x oversampling tick, start-bit validation at mid-bit and majority-free centre sampling. Presents each received byte on `data_out` with a one-cycle `rx_done` strobe and a `frame_err` flag.

## Interface
- `CLK_FREQ`, 50_000_000, system clock in Hz
- `BAUD_RATE`, 115200, line rate in bit/s
- `TICK_DIV`, CLK_FREQ/(BAUD_RATE*16) (=27, truncated), clocks per oversample tick; overridable for fast sims

- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `rxd`  in  1  serial input, idle high, asynchronous to `clk`
- `data_out`  out  8  last received byte, held until next completed frame
- `rx_done`  out  1  one-cycle pulse: frame completed, `data_out`/`frame_err` valid
- `frame_err`  out  1  stop bit sampled low on last frame; held until next frame completes
- `rx_busy`  out  1  high while state != IDLE

## Operation
- Synchronizer: two flops on `rxd`, both reset to 1; third flop holds previous synced value for falling-edge detect.
- Tick counter: 0..TICK_DIV-1, cleared on entry to START; `tick` = one-cycle pulse on wrap. Sample counter (4 bits) counts ticks within a bit; bit index (3 bits) counts data bits.
- States:
  - IDLE: on synced falling edge (prev=1, cur=0) -> START, clear tick and sample counters.
  - START: after 8 ticks (mid start bit) sample: 0 -> DATA, clear sample counter, bit index=0; 1 -> IDLE (glitch rejected, no strobe).
  - DATA: every 16 ticks sample synced `rxd`, shift into shift register from MSB side (LSB transmitted first); after bit index 7 -> STOP.
  - STOP: after 16 ticks sample: load `data_out` from shift register, `frame_err` = ~sample, pulse `rx_done`, -> IDLE.
- `data_out` updated even on framing error.
- Break (line held low): one frame with `frame_err`=1, `data_out`=0x00; no further frames until line returns high and falls again (edge-armed IDLE).
- `rxd` ignored outside sample points; no parity, 1 stop bit only.
- Reset mid-frame: state -> IDLE, counters cleared, shift register cleared, no `rx_done`; partial byte discarded.

## Timing
- Reset values: `data_out`=0x00, `rx_done`=0, `frame_err`=0, `rx_busy`=0, state IDLE.
- Edge detect latency: 3 clk from `rxd` fall to START entry (`rx_busy` rises next edge).
- Sample points: start at 8 ticks, data bit n at 8+16(n+1) ticks, stop at 8+16·9 = 152 ticks after START entry.
- `rx_done` asserted exactly 1 cycle, the cycle after stop sample tick; `data_out`, `frame_err` change on the same edge. `rx_busy` falls with `rx_done`.
- Back-to-back frames: IDLE re-entered mid stop bit, so next start edge up to 0.5 bit after stop sample is caught; tolerated baud mismatch ±3%.
- Default config: bit = 16·27 = 432 clk = 8640 ns; `rx_done` ≈ 9.5 bits (4104 clk + 4) after `rxd` fall.

## Test plan
- Loopback with `uart_tx` (`txd`->`rxd`), send 0x55, 0xAA, 0xF0 -> three `rx_done` pulses, `data_out` = 0x55, 0xAA, 0xF0, `frame_err`=0 each.
- Drive `rxd` low for 4 ticks (108 clk) then high -> no `rx_done`, `rx_busy` pulses then returns to 0 by tick 8.
- Bit-banged frame 0xA5 with stop bit 0 -> `rx_done`=1 for one cycle, `data_out`=0xA5, `frame_err`=1; next clean 0x3C frame clears `frame_err`.
- Hold `rxd` low 20 bit times -> exactly one `rx_done`, `data_out`=0x00, `frame_err`=1; release and send 0x81 -> `data_out`=0x81, `frame_err`=0.
- Assert `reset` for 1 cycle during data bit 4 of 0xFF -> no `rx_done`, outputs at reset values; following 0x12 frame received correctly.
- Back-to-back 0x00, 0xFF with zero idle, transmitter bit period 3% slow (445 clk) -> both bytes correct, `frame_err`=0.

Source files
------------

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver with 16x oversampling. A two-flop
//                synchroniser feeds a falling-edge detector that arms the
//                frame FSM. The FSM validates the start bit at mid-bit, then
//                samples each data bit and the stop bit at their centres.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int TICK_DIV  = CLK_FREQ / (BAUD_RATE * 16)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] data_out,
  output logic       rx_done,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] C_TICK_LAST = TICK_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state_q;
  logic              rxd_meta_q;
  logic              rxd_sync_q;
  logic              rxd_prev_q;
  logic [TICK_W-1:0] tick_cnt_q;
  logic [TICK_W-1:0] tick_cnt_d;
  logic [3:0]        samp_cnt_q;
  logic [2:0]        bit_idx_q;
  logic [7:0]        shift_q;
  logic [7:0]        data_q;
  logic              done_q;
  logic              ferr_q;
  logic              busy_q;
  logic              w_tick;
  logic              w_fall;

  assign w_tick = (tick_cnt_q == C_TICK_LAST);
  assign w_fall = rxd_prev_q & ~rxd_sync_q;

  assign data_out  = data_q;
  assign rx_done   = done_q;
  assign frame_err = ferr_q;
  assign rx_busy   = busy_q;

  // Two-flop synchroniser plus a history flop for falling-edge detection;
  // all reset high so reset never fabricates a start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
    end
  end

  // Oversample divider: held at zero in IDLE so it starts cleanly on START entry.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (state_q == IDLE || w_tick) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + 1'b1;
    end
  end

  // Divider register.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  // Frame FSM with registered outputs; sample points fall on oversample ticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      samp_cnt_q <= 4'd0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      data_q     <= 8'h00;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Edge-armed: a line stuck low (break) never retriggers here.
          if (w_fall) begin
            state_q    <= START;
            samp_cnt_q <= 4'd0;
            busy_q     <= 1'b1;
          end
        end
        START: begin
          if (w_tick) begin
            if (samp_cnt_q == 4'd7) begin
              samp_cnt_q <= 4'd0;
              if (!rxd_sync_q) begin
                state_q   <= DATA;
                bit_idx_q <= 3'd0;
              end else begin
                // Line back high at mid start bit: treat as a glitch.
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              samp_cnt_q <= samp_cnt_q + 4'd1;
            end
          end
        end
        DATA: begin
          if (w_tick) begin
            samp_cnt_q <= samp_cnt_q + 4'd1;
            if (samp_cnt_q == 4'd15) begin
              // LSB arrives first, so shift in from the MSB side.
              shift_q   <= {rxd_sync_q, shift_q[7:1]};
              bit_idx_q <= bit_idx_q + 3'd1;
              if (bit_idx_q == 3'd7) begin
                state_q <= STOP;
              end
            end
          end
        end
        STOP: begin
          if (w_tick) begin
            samp_cnt_q <= samp_cnt_q + 4'd1;
            if (samp_cnt_q == 4'd15) begin
              // Byte is published even on a framing error.
              data_q  <= shift_q;
              ferr_q  <= ~rxd_sync_q;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
